// File: rtl/accelerator_write_weighting.sv
// DNC write weighting: w(j) = gw * (ga*a(j) + (1-ga)*c(j)) in unsigned fixed point.
// Operands a(j), c(j) are requested one element at a time and one w(j) is emitted per index.
module accelerator_write_weighting #(
    parameter int DATA_SIZE     = 64,
    parameter int CONTROL_SIZE  = 64,
    parameter int FRACTION_SIZE = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 A_IN_ENABLE,
    input  logic                 C_IN_ENABLE,
    output logic                 A_OUT_ENABLE,
    output logic                 C_OUT_ENABLE,
    output logic                 W_OUT_ENABLE,
    input  logic [DATA_SIZE-1:0] SIZE_N_IN,
    input  logic [DATA_SIZE-1:0] GA_IN,
    input  logic [DATA_SIZE-1:0] GW_IN,
    input  logic [DATA_SIZE-1:0] A_IN,
    input  logic [DATA_SIZE-1:0] C_IN,
    output logic [DATA_SIZE-1:0] W_OUT
);

    typedef enum logic [1:0] {
        STARTER_STATE,
        INPUT_STATE,
        MULTIPLY_STATE,
        GATE_STATE
    } state_t;

    localparam logic [DATA_SIZE-1:0] ONE = {{(DATA_SIZE-1){1'b0}}, 1'b1} << FRACTION_SIZE;
    localparam int CMP_W = (DATA_SIZE > CONTROL_SIZE) ? DATA_SIZE : CONTROL_SIZE;

    state_t                  r_state;
    state_t                  w_state_next;

    logic [DATA_SIZE-1:0]    r_size;
    logic [DATA_SIZE-1:0]    r_ga;
    logic [DATA_SIZE-1:0]    r_one_minus_ga;
    logic [DATA_SIZE-1:0]    r_gw;
    logic [CONTROL_SIZE-1:0] r_index;
    logic [DATA_SIZE-1:0]    r_a;
    logic [DATA_SIZE-1:0]    r_c;
    logic                    r_a_got;
    logic                    r_c_got;
    logic [DATA_SIZE-1:0]    r_p;
    logic [DATA_SIZE-1:0]    r_w_out;
    logic                    r_w_en;
    logic                    r_ready;
    logic                    r_req;

    logic                    w_start;
    logic                    w_size_zero;
    logic                    w_last;
    logic                    w_enter_input;

    // Gate clamping: anything above ONE saturates to ONE.
    logic [DATA_SIZE-1:0]    w_gate_raw [2];
    logic [DATA_SIZE-1:0]    w_gate_sat [2];

    assign w_gate_raw[0] = GA_IN;
    assign w_gate_raw[1] = GW_IN;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_clamp
            assign w_gate_sat[gi] = (w_gate_raw[gi] > ONE) ? ONE : w_gate_raw[gi];
        end
    endgenerate

    // Interpolation: full-width products summed before the truncating shift.
    logic [2*DATA_SIZE-1:0]  w_prod_a;
    logic [2*DATA_SIZE-1:0]  w_prod_c;
    logic [2*DATA_SIZE:0]    w_sum;
    logic [DATA_SIZE-1:0]    w_p;
    logic [2*DATA_SIZE-1:0]  w_prod_w;
    logic [DATA_SIZE-1:0]    w_w;

    assign w_prod_a = {{DATA_SIZE{1'b0}}, r_ga} * {{DATA_SIZE{1'b0}}, r_a};
    assign w_prod_c = {{DATA_SIZE{1'b0}}, r_one_minus_ga} * {{DATA_SIZE{1'b0}}, r_c};
    assign w_sum    = {1'b0, w_prod_a} + {1'b0, w_prod_c};
    assign w_p      = DATA_SIZE'(w_sum >> FRACTION_SIZE);
    assign w_prod_w = {{DATA_SIZE{1'b0}}, r_gw} * {{DATA_SIZE{1'b0}}, r_p};
    assign w_w      = DATA_SIZE'(w_prod_w >> FRACTION_SIZE);

    assign w_start       = (r_state == STARTER_STATE) && START;
    assign w_size_zero   = (SIZE_N_IN == '0);
    assign w_last        = (CMP_W'(r_index) == (CMP_W'(r_size) - CMP_W'(1)));
    assign w_enter_input = (w_start && !w_size_zero) || ((r_state == GATE_STATE) && !w_last);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= STARTER_STATE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            STARTER_STATE: begin
                if (START && !w_size_zero) begin
                    w_state_next = INPUT_STATE;
                end
            end
            INPUT_STATE: begin
                // Decide on registered flags so each element spends at least two cycles here.
                if (r_a_got && r_c_got) begin
                    w_state_next = MULTIPLY_STATE;
                end
            end
            MULTIPLY_STATE: begin
                w_state_next = GATE_STATE;
            end
            GATE_STATE: begin
                w_state_next = w_last ? STARTER_STATE : INPUT_STATE;
            end
            default: begin
                w_state_next = STARTER_STATE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_size         <= '0;
            r_ga           <= '0;
            r_one_minus_ga <= '0;
            r_gw           <= '0;
            r_index        <= '0;
            r_a            <= '0;
            r_c            <= '0;
            r_a_got        <= 1'b0;
            r_c_got        <= 1'b0;
            r_p            <= '0;
            r_w_out        <= '0;
            r_w_en         <= 1'b0;
            r_ready        <= 1'b0;
            r_req          <= 1'b0;
        end else begin
            r_req   <= w_enter_input;
            r_w_en  <= 1'b0;
            r_ready <= 1'b0;
            case (r_state)
                STARTER_STATE: begin
                    if (START) begin
                        r_size         <= SIZE_N_IN;
                        r_ga           <= w_gate_sat[0];
                        r_one_minus_ga <= ONE - w_gate_sat[0];
                        r_gw           <= w_gate_sat[1];
                        r_index        <= '0;
                        r_a_got        <= 1'b0;
                        r_c_got        <= 1'b0;
                        if (w_size_zero) begin
                            r_ready <= 1'b1;
                        end
                    end
                end
                INPUT_STATE: begin
                    if (A_IN_ENABLE && !r_a_got) begin
                        r_a     <= A_IN;
                        r_a_got <= 1'b1;
                    end
                    if (C_IN_ENABLE && !r_c_got) begin
                        r_c     <= C_IN;
                        r_c_got <= 1'b1;
                    end
                end
                MULTIPLY_STATE: begin
                    r_p <= w_p;
                end
                GATE_STATE: begin
                    r_w_out <= w_w;
                    r_w_en  <= 1'b1;
                    if (w_last) begin
                        r_ready <= 1'b1;
                    end else begin
                        r_index <= r_index + CONTROL_SIZE'(1);
                        r_a_got <= 1'b0;
                        r_c_got <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign READY        = r_ready;
    assign A_OUT_ENABLE = r_req;
    assign C_OUT_ENABLE = r_req;
    assign W_OUT_ENABLE = r_w_en;
    assign W_OUT        = r_w_out;

endmodule

// File: tb/tb_accelerator_write_weighting.sv
// Self-checking bench for accelerator_write_weighting (DATA_SIZE=32, FRACTION_SIZE=16).
// A responder answers request pulses with programmable delays; results are checked against a plain-arithmetic model.
module tb_accelerator_write_weighting;

    localparam int DW = 32;
    localparam int CW = 32;
    localparam int FW = 16;
    localparam logic [63:0] ONE64 = 64'h0000_0000_0001_0000;

    logic          clk = 1'b0;
    logic          RST;
    logic          START;
    logic          READY;
    logic          A_IN_ENABLE;
    logic          C_IN_ENABLE;
    logic          A_OUT_ENABLE;
    logic          C_OUT_ENABLE;
    logic          W_OUT_ENABLE;
    logic [DW-1:0] SIZE_N_IN;
    logic [DW-1:0] GA_IN;
    logic [DW-1:0] GW_IN;
    logic [DW-1:0] A_IN;
    logic [DW-1:0] C_IN;
    logic [DW-1:0] W_OUT;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] va [16];
    logic [DW-1:0] vc [16];
    int            da [16];
    int            dc [16];
    bit            extra_a;

    accelerator_write_weighting #(
        .DATA_SIZE     (DW),
        .CONTROL_SIZE  (CW),
        .FRACTION_SIZE (FW)
    ) dut (
        .CLK          (clk),
        .RST          (RST),
        .START        (START),
        .READY        (READY),
        .A_IN_ENABLE  (A_IN_ENABLE),
        .C_IN_ENABLE  (C_IN_ENABLE),
        .A_OUT_ENABLE (A_OUT_ENABLE),
        .C_OUT_ENABLE (C_OUT_ENABLE),
        .W_OUT_ENABLE (W_OUT_ENABLE),
        .SIZE_N_IN    (SIZE_N_IN),
        .GA_IN        (GA_IN),
        .GW_IN        (GW_IN),
        .A_IN         (A_IN),
        .C_IN         (C_IN),
        .W_OUT        (W_OUT)
    );

    always #5 clk = ~clk;

    // Reference: w = gw * (ga*a + (1-ga)*c), gates saturated at ONE, truncating shifts.
    function automatic logic [DW-1:0] ref_w(input logic [DW-1:0] ga, input logic [DW-1:0] gw,
                                            input logic [DW-1:0] a, input logic [DW-1:0] c);
        logic [63:0] g;
        logic [63:0] h;
        logic [63:0] mix;
        logic [63:0] w;
        g   = (64'(ga) > ONE64) ? ONE64 : 64'(ga);
        h   = (64'(gw) > ONE64) ? ONE64 : 64'(gw);
        mix = ((g * 64'(a)) + ((ONE64 - g) * 64'(c))) >> FW;
        mix = mix & 64'h0000_0000_FFFF_FFFF;
        w   = (h * mix) >> FW;
        return w[DW-1:0];
    endfunction

    task automatic check_idle_outputs(input string name);
        n_cmp++; if (READY !== 1'b0) begin n_bad++; $display("FAIL %s_ready got=%b want=0", name, READY); end
        n_cmp++; if (W_OUT_ENABLE !== 1'b0) begin n_bad++; $display("FAIL %s_wen got=%b want=0", name, W_OUT_ENABLE); end
        n_cmp++; if (A_OUT_ENABLE !== 1'b0) begin n_bad++; $display("FAIL %s_areq got=%b want=0", name, A_OUT_ENABLE); end
        n_cmp++; if (C_OUT_ENABLE !== 1'b0) begin n_bad++; $display("FAIL %s_creq got=%b want=0", name, C_OUT_ENABLE); end
        n_cmp++; if (W_OUT !== '0) begin n_bad++; $display("FAIL %s_wout got=%h want=0", name, W_OUT); end
    endtask

    // Runs one vector: START, answer every request, check each w element, READY and latency.
    task automatic drive_vector(input string name, input int n, input logic [DW-1:0] ga,
                                input logic [DW-1:0] gw, input int abort_at, input bit glitch);
        logic [DW-1:0] expv [16];
        int  cyc, req_cnt, w_cnt, rdy_cnt, elem, t_req, last_drv, rdy_cyc, budget;
        bit  pending, a_done, c_done, aborted, exp_rdy;
        for (int j = 0; j < 16; j++) expv[j] = (j < n) ? ref_w(ga, gw, va[j], vc[j]) : '0;
        @(negedge clk);
        START = 1'b1; SIZE_N_IN = DW'(n); GA_IN = ga; GW_IN = gw;
        cyc = 0; req_cnt = 0; w_cnt = 0; rdy_cnt = 0; elem = 0; t_req = 0;
        last_drv = -100; rdy_cyc = -1; budget = 40 * n + 40;
        pending = 1'b0; a_done = 1'b0; c_done = 1'b0; aborted = 1'b0;
        while (cyc < budget && !aborted && !(rdy_cyc >= 0 && cyc >= rdy_cyc + 3)) begin
            @(negedge clk);
            cyc++;
            START = 1'b0; A_IN_ENABLE = 1'b0; C_IN_ENABLE = 1'b0;
            GA_IN = $urandom; GW_IN = $urandom; SIZE_N_IN = DW'($urandom_range(0, 15));
            n_cmp++;
            if (A_OUT_ENABLE !== C_OUT_ENABLE) begin
                n_bad++; $display("FAIL %s_req_align cyc=%0d a_req=%b c_req=%b", name, cyc, A_OUT_ENABLE, C_OUT_ENABLE);
            end
            if (A_OUT_ENABLE === 1'b1) begin
                req_cnt++;
                if (elem < n) begin
                    t_req = cyc; pending = 1'b1; a_done = 1'b0; c_done = 1'b0;
                end
            end
            if (W_OUT_ENABLE === 1'b1) begin
                exp_rdy = (w_cnt == n - 1);
                n_cmp++;
                if (w_cnt >= n || W_OUT !== expv[w_cnt]) begin
                    n_bad++; $display("FAIL %s_wout elem=%0d got=%h want=%h", name, w_cnt, W_OUT, expv[w_cnt & 15]);
                end
                n_cmp++;
                if (READY !== exp_rdy) begin
                    n_bad++; $display("FAIL %s_ready_with_w elem=%0d got=%b want=%b", name, w_cnt, READY, exp_rdy);
                end
                n_cmp++;
                if (cyc != last_drv + 4) begin
                    n_bad++; $display("FAIL %s_latency elem=%0d got_cyc=%0d want_cyc=%0d", name, w_cnt, cyc, last_drv + 4);
                end
                w_cnt++;
                if (abort_at > 0 && w_cnt == abort_at) begin
                    RST = 1'b1; aborted = 1'b1;
                end
            end
            if (READY === 1'b1) begin
                rdy_cnt++;
                if (rdy_cyc < 0) rdy_cyc = cyc;
            end
            if (glitch && elem == 0 && pending && cyc == t_req + 1) begin
                START = 1'b1; GA_IN = ga ^ 32'h0000_C000; GW_IN = gw ^ 32'h0000_2000; SIZE_N_IN = 32'd1;
            end
            if (pending && !aborted) begin
                if (cyc == t_req + dc[elem]) begin
                    C_IN_ENABLE = 1'b1; C_IN = vc[elem]; c_done = 1'b1;
                end
                if (cyc == t_req + da[elem]) begin
                    A_IN_ENABLE = 1'b1; A_IN = va[elem]; a_done = 1'b1;
                end else if (extra_a && a_done && !c_done) begin
                    A_IN_ENABLE = 1'b1; A_IN = $urandom;
                end
                if (a_done && c_done) begin
                    pending = 1'b0; last_drv = cyc; elem++;
                end
            end
        end
        if (aborted) begin
            @(negedge clk);
            check_idle_outputs({name, "_after_rst"});
            RST = 1'b0;
            $display("%s: n=%0d aborted after %0d elements, outputs cleared", name, n, w_cnt);
        end else begin
            n_cmp++;
            if (rdy_cyc < 0) begin n_bad++; $display("FAIL %s_timeout got=no_ready want=ready within %0d cycles", name, budget); end
            n_cmp++;
            if (req_cnt != n) begin n_bad++; $display("FAIL %s_req_count got=%0d want=%0d", name, req_cnt, n); end
            n_cmp++;
            if (w_cnt != n) begin n_bad++; $display("FAIL %s_w_count got=%0d want=%0d", name, w_cnt, n); end
            n_cmp++;
            if (rdy_cnt != 1) begin n_bad++; $display("FAIL %s_ready_count got=%0d want=1", name, rdy_cnt); end
            if (n == 0) begin
                n_cmp++;
                if (rdy_cyc != 1) begin n_bad++; $display("FAIL %s_ready_cycle got=%0d want=1", name, rdy_cyc); end
            end
            $display("%s: n=%0d ga=%h gw=%h requests=%0d w_pulses=%0d ready_pulses=%0d", name, n, ga, gw, req_cnt, w_cnt, rdy_cnt);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        RST = 1'b0;
        $display("test_reset: outputs checked during reset");
    endtask

    task automatic test_n_zero();
        extra_a = 1'b0;
        drive_vector("n_zero", 0, 32'h8000, 32'h10000, 0, 1'b0);
        n_cmp++;
        if (W_OUT !== '0) begin n_bad++; $display("FAIL n_zero_wout got=%h want=0", W_OUT); end
    endtask

    task automatic test_basic();
        extra_a = 1'b0;
        va[0] = 32'h20000; vc[0] = 32'h40000; da[0] = 0; dc[0] = 0;
        drive_vector("basic", 1, 32'h8000, 32'h10000, 0, 1'b0);
        n_cmp++;
        if (W_OUT !== 32'h30000) begin n_bad++; $display("FAIL basic_const got=%h want=00030000", W_OUT); end
        drive_vector("gw_quarter", 1, 32'h8000, 32'h4000, 0, 1'b0);
        n_cmp++;
        if (W_OUT !== 32'h0C000) begin n_bad++; $display("FAIL gw_quarter_const got=%h want=0000c000", W_OUT); end
        drive_vector("ga_clamp", 1, 32'h18000, 32'h10000, 0, 1'b0);
        n_cmp++;
        if (W_OUT !== 32'h20000) begin n_bad++; $display("FAIL ga_clamp_const got=%h want=00020000", W_OUT); end
    endtask

    task automatic test_multi();
        extra_a = 1'b1;
        for (int j = 0; j < 4; j++) begin
            va[j] = $urandom; vc[j] = $urandom; da[j] = j & 1; dc[j] = da[j] + 2;
        end
        drive_vector("multi_c_late", 4, 32'h6000, 32'hE000, 0, 1'b0);
        extra_a = 1'b0;
    endtask

    task automatic test_reset_mid();
        extra_a = 1'b0;
        for (int j = 0; j < 4; j++) begin
            va[j] = $urandom; vc[j] = $urandom; da[j] = 1; dc[j] = 0;
        end
        drive_vector("reset_mid", 4, 32'hA000, 32'hF000, 2, 1'b0);
        for (int j = 0; j < 4; j++) begin
            va[j] = $urandom; vc[j] = $urandom; da[j] = $urandom_range(0, 3); dc[j] = $urandom_range(0, 3);
        end
        drive_vector("after_reset", 4, 32'h3000, 32'h10000, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        extra_a = 1'b0;
        for (int j = 0; j < 3; j++) begin
            va[j] = $urandom; vc[j] = $urandom; da[j] = 2; dc[j] = 3;
        end
        drive_vector("start_ignored", 3, 32'h4000, 32'hC000, 0, 1'b1);
    endtask

    task automatic test_random();
        int n;
        logic [DW-1:0] ga, gw;
        for (int k = 0; k < 8; k++) begin
            n  = $urandom_range(1, 8);
            ga = $urandom_range(0, 32'h14000);
            gw = $urandom_range(0, 32'h14000);
            extra_a = 1'($urandom_range(0, 1));
            for (int j = 0; j < 16; j++) begin
                va[j] = $urandom; vc[j] = $urandom;
                da[j] = $urandom_range(0, 4); dc[j] = $urandom_range(0, 4);
            end
            drive_vector("random", n, ga, gw, 0, 1'b0);
        end
        extra_a = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=still_running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST = 1'b1; START = 1'b0; A_IN_ENABLE = 1'b0; C_IN_ENABLE = 1'b0;
        SIZE_N_IN = '0; GA_IN = '0; GW_IN = '0; A_IN = '0; C_IN = '0;
        extra_a = 1'b0;
        for (int j = 0; j < 16; j++) begin
            va[j] = '0; vc[j] = '0; da[j] = 0; dc[j] = 0;
        end
        test_reset();
        test_n_zero();
        test_basic();
        test_multi();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
